display_ctrl: RTL and testbench
===============================

// Module: display_ctrl
// PURPOSE
//  Front-end controller for the 7-digit effect display. It sits upstream of the effect engines.
//  Its outputs drive their char0..char6, enable and frequency inputs.
//  Debounces two push-buttons that step the effect select and blink frequency.
//  Assembles STX..ETX framed messages from a UART byte stream into the 7 display characters.
//  Updates all 7 characters in one cycle when a frame commits.
// PARAMETERS
//  DEBOUNCE_CYCLES  1000000  cycles a synced button level must hold before it is accepted (20 ms @ 50 MHz)
//  NUM_EFFECTS      4        number of effect codes; enable counts 0..NUM_EFFECTS-1 (max 8)
//  TIMEOUT_CYCLES   50000000 idle cycles allowed between bytes inside a frame before abort
// PORTS
//  clk        in   1  system clock, 50 MHz
//  rst        in   1  synchronous reset, active-high
//  btn_mode   in   1  raw button, 1 = pressed, asynchronous
//  btn_freq   in   1  raw button, 1 = pressed, asynchronous
//  rx_data    in   8  received byte, valid only while rx_valid = 1
//  rx_valid   in   1  one-cycle strobe per received byte
//  char0..6   out  7  display character codes (ASCII[6:0]); char0 = leftmost digit
//  enable     out  3  effect select
//  frequency  out  2  blink rate: 00 = 0.5 Hz, 01 = 1 Hz, 10 = 2 Hz, 11 = 4 Hz
//  load_done  out  1  one-cycle pulse when a frame commits
//  load_err   out  1  one-cycle pulse when a frame is aborted
// BEHAVIOUR
//  Reset values:
//   - char0..6 = 7'h20 (space); enable = 0; frequency = 2'b01
//   - load_done = 0; load_err = 0; FSM = IDLE; shadow buffer cleared; debounce counters = 0
//  Buttons:
//   - Each button passes through a 2-flop synchronizer.
//   - A counter runs while the synced level differs from the debounced level and clears when they match.
//   - At DEBOUNCE_CYCLES consecutive mismatching cycles, the debounced level flips.
//   - A 0->1 flip of the debounced level registers a press.
//   - btn_mode press: enable <= (enable == NUM_EFFECTS-1) ? 0 : enable+1, applied the cycle after the flip.
//   - btn_freq press: frequency <= frequency+1 (wraps 11->00), same timing.
//   - A release (1->0 flip) has no effect. Holding a button gives exactly one step.
//   - Both buttons pressed in the same cycle: both updates are applied.
//  Frame FSM states: IDLE, LOAD.
//   - IDLE: on rx byte 8'h02 -> LOAD; idx = 0; shadow = all 7'h20. All other bytes are ignored.
//   - LOAD, byte 8'h03 (ETX): next cycle char[k] <= shadow[k] for all k, load_done = 1, FSM -> IDLE.
//     Unfilled positions stay 7'h20. ETX with idx = 0 commits all spaces.
//   - LOAD, byte 8'h02: restart (idx = 0, shadow = spaces). No error is raised.
//   - LOAD, byte 8'h20..8'h7E with idx < 7: shadow[idx] <= byte[6:0]; idx++.
//   - LOAD abort conditions, each giving load_err = 1 next cycle and FSM -> IDLE:
//     - printable byte while idx == 7 (overlong frame);
//     - any other byte (control character or bit7 = 1);
//     - TIMEOUT_CYCLES cycles with no rx_valid.
//     On abort, char0..6 are unchanged.
//   - The timeout counter clears on every rx_valid and is only active in LOAD.
//  Outputs char*, enable and frequency are registered and change only at the events above.
//  Frame commits and button steps are independent; both may occur in the same cycle.
//  rst asserted mid-frame discards the shadow buffer. No load_done or load_err pulse is produced.
//  rst has priority over all other events.
// TESTING
//  - Reset then idle 10 cycles -> char0..6 = 7'h20, enable = 0, frequency = 01, no pulses.
//  - DEBOUNCE_CYCLES = 4:
//    - btn_mode high for 3 cycles, then low -> enable stays 0.
//    - btn_mode held high for 20 cycles -> enable = 1 exactly once.
//    - 4 further presses with NUM_EFFECTS = 4 -> enable sequence 2, 3, 0, 1.
//  - rx sequence 02 'H' 'E' 'L' 'L' 'O' 03 -> one load_done pulse; char0..6 = 48 45 4C 4C 4F 20 20.
//  - rx sequence 02 + 8 printable bytes -> load_err on the 8th byte; chars unchanged.
//  - rx sequence 02 'A' 02 'B' 03 -> char0 = 42, char1..6 = 20.
//  - TIMEOUT_CYCLES = 16:
//    - 02 'A' then 16 idle cycles -> load_err, chars unchanged.
//    - Assert rst mid-frame -> no pulses; outputs return to reset values.

Source files
------------

// File: rtl/display_ctrl.sv
// Front-end controller for the 7-digit effect display: debounced mode/frequency
// buttons and a STX..ETX framed UART loader that commits all 7 characters at once.
module display_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned NUM_EFFECTS     = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_freq,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [6:0] char0,
  output logic [6:0] char1,
  output logic [6:0] char2,
  output logic [6:0] char3,
  output logic [6:0] char4,
  output logic [6:0] char5,
  output logic [6:0] char6,
  output logic [2:0] enable,
  output logic [1:0] frequency,
  output logic       load_done,
  output logic       load_err
);

  localparam int unsigned NUM_CHARS = 7;
  localparam int unsigned DB_W      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned TO_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [7:0]  STX       = 8'h02;
  localparam logic [7:0]  ETX       = 8'h03;
  localparam logic [6:0]  SPACE     = 7'h20;
  localparam logic [2:0]  LAST_IDX  = 3'(NUM_CHARS);
  localparam logic [2:0]  LAST_FX   = 3'(NUM_EFFECTS - 1);

  typedef enum logic {S_IDLE, S_LOAD} state_t;

  // ---------------------------------------------------------------------------
  // Button synchronise + debounce; bit 0 = mode, bit 1 = freq
  // ---------------------------------------------------------------------------
  logic [1:0]      w_btn_raw;
  logic [1:0]      w_press;
  logic [1:0]      r_sync1;
  logic [1:0]      r_sync2;
  logic [1:0]      r_deb;
  logic [1:0]      r_deb_q;
  logic [DB_W-1:0] r_db_cnt [2];

  assign w_btn_raw = {btn_freq, btn_mode};
  assign w_press   = r_deb & ~r_deb_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      r_deb_q <= '0;
      for (int i = 0; i < 2; i++) r_db_cnt[i] <= '0;
    end else begin
      r_sync1 <= w_btn_raw;
      r_sync2 <= r_sync1;
      r_deb_q <= r_deb;
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] != r_deb[i]) begin
          if (r_db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            r_deb[i]    <= r_sync2[i];
            r_db_cnt[i] <= '0;
          end else begin
            r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
          end
        end else begin
          r_db_cnt[i] <= '0;
        end
      end
    end
  end

  // Effect select and blink rate step once per debounced rising edge
  logic [2:0] r_enable;
  logic [1:0] r_frequency;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_enable    <= 3'd0;
      r_frequency <= 2'b01;
    end else begin
      if (w_press[0]) r_enable <= (r_enable == LAST_FX) ? 3'd0 : r_enable + 3'd1;
      if (w_press[1]) r_frequency <= r_frequency + 2'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame loader: bytes collect in a shadow buffer, ETX copies it out in one cycle
  // ---------------------------------------------------------------------------
  state_t          r_state;
  logic [2:0]      r_idx;
  logic [6:0]      r_shadow [NUM_CHARS];
  logic [6:0]      r_char   [NUM_CHARS];
  logic [TO_W-1:0] r_to_cnt;
  logic            r_load_done;
  logic            r_load_err;
  logic            w_printable;

  assign w_printable = (rx_data >= 8'h20) && (rx_data <= 8'h7E);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_idx       <= 3'd0;
      r_to_cnt    <= '0;
      r_load_done <= 1'b0;
      r_load_err  <= 1'b0;
      for (int k = 0; k < NUM_CHARS; k++) begin
        r_shadow[k] <= SPACE;
        r_char[k]   <= SPACE;
      end
    end else begin
      r_load_done <= 1'b0;
      r_load_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_to_cnt <= '0;
          if (rx_valid && (rx_data == STX)) begin
            r_state <= S_LOAD;
            r_idx   <= 3'd0;
            for (int k = 0; k < NUM_CHARS; k++) r_shadow[k] <= SPACE;
          end
        end
        S_LOAD: begin
          if (rx_valid) begin
            r_to_cnt <= '0;
            if (rx_data == ETX) begin
              for (int k = 0; k < NUM_CHARS; k++) r_char[k] <= r_shadow[k];
              r_load_done <= 1'b1;
              r_state     <= S_IDLE;
            end else if (rx_data == STX) begin
              r_idx <= 3'd0;
              for (int k = 0; k < NUM_CHARS; k++) r_shadow[k] <= SPACE;
            end else if (w_printable && (r_idx != LAST_IDX)) begin
              r_shadow[r_idx] <= rx_data[6:0];
              r_idx           <= r_idx + 3'd1;
            end else begin
              // overlong frame, control character or bit7 set
              r_load_err <= 1'b1;
              r_state    <= S_IDLE;
            end
          end else if (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
            r_load_err <= 1'b1;
            r_to_cnt   <= '0;
            r_state    <= S_IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign char0     = r_char[0];
  assign char1     = r_char[1];
  assign char2     = r_char[2];
  assign char3     = r_char[3];
  assign char4     = r_char[4];
  assign char5     = r_char[5];
  assign char6     = r_char[6];
  assign enable    = r_enable;
  assign frequency = r_frequency;
  assign load_done = r_load_done;
  assign load_err  = r_load_err;

endmodule

// File: tb/tb_display_ctrl.sv
// Directed bench for display_ctrl with short debounce (4) and timeout (16) settings.
module tb_display_ctrl;

  logic       clk;
  logic       rst;
  logic       btn_mode;
  logic       btn_freq;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [6:0] c0, c1, c2, c3, c4, c5, c6;
  logic [2:0] enable;
  logic [1:0] frequency;
  logic       load_done;
  logic       load_err;

  logic [6:0] ch     [7];
  logic [6:0] exp_ch [7];

  int n_cmp;
  int n_fail;
  int done_seen;
  int err_seen;
  int en_changes;
  logic [2:0] prev_en;

  display_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .NUM_EFFECTS    (4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_mode (btn_mode),
    .btn_freq (btn_freq),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .char0    (c0),
    .char1    (c1),
    .char2    (c2),
    .char3    (c3),
    .char4    (c4),
    .char5    (c5),
    .char6    (c6),
    .enable   (enable),
    .frequency(frequency),
    .load_done(load_done),
    .load_err (load_err)
  );

  assign ch[0] = c0;
  assign ch[1] = c1;
  assign ch[2] = c2;
  assign ch[3] = c3;
  assign ch[4] = c4;
  assign ch[5] = c5;
  assign ch[6] = c6;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock; outputs sampled 1 ns after the edge, pulses and enable steps tallied
  task automatic tick();
    @(posedge clk);
    #1;
    if (load_done === 1'b1) done_seen++;
    if (load_err === 1'b1) err_seen++;
    if (enable !== prev_en) en_changes++;
    prev_en = enable;
  endtask

  task automatic hold_btn(input logic m, input logic f, input int hold, input int rel);
    btn_mode = m;
    btn_freq = f;
    repeat (hold) tick();
    btn_mode = 1'b0;
    btn_freq = 1'b0;
    repeat (rel) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic set_exp(input logic [6:0] a, input logic [6:0] b, input logic [6:0] c,
                         input logic [6:0] d, input logic [6:0] e, input logic [6:0] f,
                         input logic [6:0] g);
    exp_ch[0] = a; exp_ch[1] = b; exp_ch[2] = c; exp_ch[3] = d;
    exp_ch[4] = e; exp_ch[5] = f; exp_ch[6] = g;
  endtask

  task automatic test_reset();
    int d0, e0;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    d0 = done_seen; e0 = err_seen;
    repeat (10) tick();
    set_exp(7'h20, 7'h20, 7'h20, 7'h20, 7'h20, 7'h20, 7'h20);
    for (int k = 0; k < 7; k++) begin
      n_cmp++;
      if (ch[k] !== exp_ch[k]) begin
        n_fail++; $display("FAIL reset_char%0d got %h want %h", k, ch[k], exp_ch[k]);
      end
    end
    n_cmp++;
    if (enable !== 3'd0) begin n_fail++; $display("FAIL reset_enable got %0d want 0", enable); end
    n_cmp++;
    if (frequency !== 2'b01) begin n_fail++; $display("FAIL reset_freq got %b want 01", frequency); end
    n_cmp++;
    if ((done_seen - d0) !== 0 || (err_seen - e0) !== 0) begin
      n_fail++; $display("FAIL reset_pulses done %0d err %0d want 0 0", done_seen - d0, err_seen - e0);
    end
  endtask

  task automatic test_glitch();
    hold_btn(1'b1, 1'b0, 3, 10);
    n_cmp++;
    if (enable !== 3'd0) begin n_fail++; $display("FAIL glitch_enable got %0d want 0", enable); end
  endtask

  task automatic test_mode_press();
    int c0_chg;
    c0_chg = en_changes;
    hold_btn(1'b1, 1'b0, 20, 10);
    n_cmp++;
    if (enable !== 3'd1) begin n_fail++; $display("FAIL hold_enable got %0d want 1", enable); end
    n_cmp++;
    if ((en_changes - c0_chg) !== 1) begin
      n_fail++; $display("FAIL hold_steps got %0d want 1", en_changes - c0_chg);
    end
  endtask

  task automatic test_mode_sequence();
    logic [2:0] exp_seq [4];
    exp_seq[0] = 3'd2; exp_seq[1] = 3'd3; exp_seq[2] = 3'd0; exp_seq[3] = 3'd1;
    for (int i = 0; i < 4; i++) begin
      hold_btn(1'b1, 1'b0, 10, 10);
      n_cmp++;
      if (enable !== exp_seq[i]) begin
        n_fail++; $display("FAIL mode_seq%0d got %0d want %0d", i, enable, exp_seq[i]);
      end
    end
  endtask

  task automatic test_freq_and_both();
    hold_btn(1'b0, 1'b1, 10, 10);
    n_cmp++;
    if (frequency !== 2'b10 || enable !== 3'd1) begin
      n_fail++; $display("FAIL freq_step freq %b en %0d want 10 1", frequency, enable);
    end
    hold_btn(1'b1, 1'b1, 10, 10);
    n_cmp++;
    if (frequency !== 2'b11 || enable !== 3'd2) begin
      n_fail++; $display("FAIL both_step freq %b en %0d want 11 2", frequency, enable);
    end
    hold_btn(1'b0, 1'b1, 10, 10);
    n_cmp++;
    if (frequency !== 2'b00) begin n_fail++; $display("FAIL freq_wrap got %b want 00", frequency); end
  endtask

  task automatic test_hello();
    int d0, e0;
    d0 = done_seen; e0 = err_seen;
    send_byte(8'h02); send_byte(8'h48); send_byte(8'h45); send_byte(8'h4C);
    send_byte(8'h4C); send_byte(8'h4F); send_byte(8'h03);
    repeat (3) tick();
    set_exp(7'h48, 7'h45, 7'h4C, 7'h4C, 7'h4F, 7'h20, 7'h20);
    for (int k = 0; k < 7; k++) begin
      n_cmp++;
      if (ch[k] !== exp_ch[k]) begin
        n_fail++; $display("FAIL hello_char%0d got %h want %h", k, ch[k], exp_ch[k]);
      end
    end
    n_cmp++;
    if ((done_seen - d0) !== 1 || (err_seen - e0) !== 0) begin
      n_fail++; $display("FAIL hello_pulses done %0d err %0d want 1 0", done_seen - d0, err_seen - e0);
    end
  endtask

  task automatic test_overlong();
    int d0, e0;
    d0 = done_seen; e0 = err_seen;
    send_byte(8'h02);
    for (int i = 0; i < 7; i++) send_byte(8'h41 + 8'(i));
    n_cmp++;
    if (load_err !== 1'b0) begin n_fail++; $display("FAIL overlong_7th got err %b want 0", load_err); end
    send_byte(8'h48);
    n_cmp++;
    if (load_err !== 1'b1) begin n_fail++; $display("FAIL overlong_8th got err %b want 1", load_err); end
    repeat (3) tick();
    n_cmp++;
    if ((done_seen - d0) !== 0 || (err_seen - e0) !== 1) begin
      n_fail++; $display("FAIL overlong_pulses done %0d err %0d want 0 1", done_seen - d0, err_seen - e0);
    end
    for (int k = 0; k < 7; k++) begin
      n_cmp++;
      if (ch[k] !== exp_ch[k]) begin
        n_fail++; $display("FAIL overlong_char%0d got %h want %h", k, ch[k], exp_ch[k]);
      end
    end
  endtask

  task automatic test_restart();
    int d0, e0;
    d0 = done_seen; e0 = err_seen;
    send_byte(8'h02); send_byte(8'h41); send_byte(8'h02); send_byte(8'h42); send_byte(8'h03);
    repeat (2) tick();
    set_exp(7'h42, 7'h20, 7'h20, 7'h20, 7'h20, 7'h20, 7'h20);
    for (int k = 0; k < 7; k++) begin
      n_cmp++;
      if (ch[k] !== exp_ch[k]) begin
        n_fail++; $display("FAIL restart_char%0d got %h want %h", k, ch[k], exp_ch[k]);
      end
    end
    n_cmp++;
    if ((done_seen - d0) !== 1 || (err_seen - e0) !== 0) begin
      n_fail++; $display("FAIL restart_pulses done %0d err %0d want 1 0", done_seen - d0, err_seen - e0);
    end
  endtask

  task automatic test_bad_byte();
    send_byte(8'h02); send_byte(8'h41); send_byte(8'h7F);
    n_cmp++;
    if (load_err !== 1'b1) begin n_fail++; $display("FAIL badbyte_err got %b want 1", load_err); end
    tick();
    n_cmp++;
    if (c0 !== 7'h42) begin n_fail++; $display("FAIL badbyte_char0 got %h want 42", c0); end
  endtask

  task automatic test_timeout();
    int e0;
    send_byte(8'h02); send_byte(8'h41);
    e0 = err_seen;
    repeat (15) tick();
    n_cmp++;
    if ((err_seen - e0) !== 0) begin n_fail++; $display("FAIL timeout_early got %0d errs want 0", err_seen - e0); end
    tick();
    n_cmp++;
    if (load_err !== 1'b1) begin n_fail++; $display("FAIL timeout_err got %b want 1", load_err); end
    tick();
    n_cmp++;
    if (c0 !== 7'h42 || c1 !== 7'h20) begin
      n_fail++; $display("FAIL timeout_chars got %h %h want 42 20", c0, c1);
    end
  endtask

  task automatic test_empty_frame();
    int d0;
    d0 = done_seen;
    send_byte(8'h02); send_byte(8'h03);
    tick();
    n_cmp++;
    if ((done_seen - d0) !== 1) begin n_fail++; $display("FAIL empty_done got %0d want 1", done_seen - d0); end
    n_cmp++;
    if (c0 !== 7'h20) begin n_fail++; $display("FAIL empty_char0 got %h want 20", c0); end
  endtask

  task automatic test_rst_mid_frame();
    int d0, e0;
    send_byte(8'h02); send_byte(8'h5A); send_byte(8'h03);
    tick();
    n_cmp++;
    if (c0 !== 7'h5A) begin n_fail++; $display("FAIL pre_rst_char0 got %h want 5a", c0); end
    d0 = done_seen; e0 = err_seen;
    send_byte(8'h02); send_byte(8'h58); send_byte(8'h59);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (3) tick();
    send_byte(8'h03);
    repeat (3) tick();
    n_cmp++;
    if ((done_seen - d0) !== 0 || (err_seen - e0) !== 0) begin
      n_fail++; $display("FAIL rst_mid_pulses done %0d err %0d want 0 0", done_seen - d0, err_seen - e0);
    end
    n_cmp++;
    if (c0 !== 7'h20 || c1 !== 7'h20) begin
      n_fail++; $display("FAIL rst_mid_chars got %h %h want 20 20", c0, c1);
    end
    n_cmp++;
    if (enable !== 3'd0 || frequency !== 2'b01) begin
      n_fail++; $display("FAIL rst_mid_ctrl en %0d freq %b want 0 01", enable, frequency);
    end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; done_seen = 0; err_seen = 0; en_changes = 0;
    prev_en  = 3'd0;
    rst      = 1'b1;
    btn_mode = 1'b0;
    btn_freq = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    test_reset();
    test_glitch();
    test_mode_press();
    test_mode_sequence();
    test_freq_and_both();
    test_hello();
    test_overlong();
    test_restart();
    test_bad_byte();
    test_timeout();
    test_empty_frame();
    test_rst_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
